// File: rtl/obs_daq_acc.sv
`default_nettype none
// ============================================================================
// Module   : obs_daq_acc
// Brief    : DAQ-side receiver of the observation-sequencer control lines.
//            Accumulates ADC samples over each adc_en window and queues one
//            tagged record (rotation point, source, count, sum) per window
//            in a first-word-fall-through FIFO with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module obs_daq_acc #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk50,
  input  logic                    sys_init_n,
  input  logic                    wrk_stat,
  input  logic                    adc_en,
  input  logic [3:0]              rf_sw,
  input  logic [9:0]              rot_count,
  input  logic                    adc_valid,
  input  logic [DATA_W-1:0]       adc_data,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [9:0]              rec_rot,
  output logic [1:0]              rec_src,
  output logic                    rec_err,
  output logic [CNT_W-1:0]        rec_cnt,
  output logic [DATA_W+CNT_W-1:0] rec_sum,
  output logic                    ovf,
  output logic                    sw_err
);

  localparam int SUM_W  = DATA_W + CNT_W;
  localparam int REC_W  = 10 + 2 + 1 + CNT_W + SUM_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SYNC_W = 1 + 1 + 4 + 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_PUSH = 2'd2
  } state_e;

  // Synchronizer chain, all slow control lines packed together
  logic [SYNC_W-1:0] sync_meta_q, sync_meta_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic              adc_en_d_q, adc_en_d_d;

  logic       wrk_stat_s;
  logic       adc_en_s;
  logic [3:0] rf_sw_s;
  logic [9:0] rot_count_s;

  assign wrk_stat_s  = sync_q[15];
  assign adc_en_s    = sync_q[14];
  assign rf_sw_s     = sync_q[13:10];
  assign rot_count_s = sync_q[9:0];

  // Window accumulator state
  state_e            state_q, state_d;
  logic [9:0]        rot_q, rot_d;
  logic [3:0]        rfsw_q, rfsw_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              ovf_q, ovf_d;
  logic              sw_err_q, sw_err_d;

  // Record FIFO
  logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              rec_valid_q, rec_valid_d;

  logic              rise, fall;
  logic              push, pop, full;
  logic              sw_bad;
  logic [1:0]        src;
  logic [REC_W-1:0]  rec_wdata;
  logic [REC_W-1:0]  rec_head;

  // Decode the latched source select and form the record to be written
  always_comb begin
    src    = 2'd0;
    sw_bad = 1'b0;
    case (rfsw_q)
      4'b0001: src = 2'd0;
      4'b0010: src = 2'd1;
      4'b0100: src = 2'd2;
      4'b1000: src = 2'd3;
      default: sw_bad = 1'b1;
    endcase
    rec_wdata = {rot_q, src, (sw_bad | sat_q), cnt_q, sum_q};
  end

  // Next-state logic: synchronizers, window FSM, sticky flags and FIFO control
  always_comb begin
    sync_meta_d = {wrk_stat, adc_en, rf_sw, rot_count};
    sync_d      = sync_meta_q;
    adc_en_d_d  = adc_en_s;

    rise = adc_en_s & ~adc_en_d_q;
    fall = ~adc_en_s & adc_en_d_q;

    state_d  = state_q;
    rot_d    = rot_q;
    rfsw_d   = rfsw_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    ovf_d    = ovf_q;
    sw_err_d = sw_err_q;

    pop  = rec_valid_q & rec_ready;
    full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    push = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise && wrk_stat_s) begin
          state_d = S_ACC;
          rot_d   = rot_count_s;
          rfsw_d  = rf_sw_s;
          sum_d   = adc_valid ? SUM_W'(adc_data) : '0;
          cnt_d   = CNT_W'(adc_valid);
          sat_d   = 1'b0;
          if (!(rf_sw_s == 4'b0001 || rf_sw_s == 4'b0010 ||
                rf_sw_s == 4'b0100 || rf_sw_s == 4'b1000)) begin
            sw_err_d = 1'b1;
          end
        end
      end
      S_ACC: begin
        if (!wrk_stat_s) begin
          // Sequencer stopped mid-window: discard without a record
          state_d = S_IDLE;
        end else if (fall) begin
          state_d = S_PUSH;
        end else if (adc_valid) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            sum_d = sum_q + SUM_W'(adc_data);
            cnt_d = cnt_q + 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end
      end
      S_PUSH: begin
        // A simultaneous pop frees a slot, so a full FIFO still accepts
        if (!full || pop) begin
          push = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    // Entries written last cycle become visible now; a pop hides its entry
    rec_valid_d = ((count_q - (PTR_W+1)'(pop)) != '0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk50) begin
    if (!sys_init_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      adc_en_d_q  <= 1'b0;
      state_q     <= S_IDLE;
      rot_q       <= '0;
      rfsw_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      sw_err_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rec_valid_q <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      adc_en_d_q  <= adc_en_d_d;
      state_q     <= state_d;
      rot_q       <= rot_d;
      rfsw_q      <= rfsw_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
      sw_err_q    <= sw_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rec_valid_q <= rec_valid_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark it empty
  always_ff @(posedge clk50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rec_wdata;
    end
  end

  assign rec_head  = rec_valid_q ? mem_q[rd_ptr_q] : '0;
  assign rec_valid = rec_valid_q;
  assign rec_rot   = rec_head[REC_W-1 -: 10];
  assign rec_src   = rec_head[REC_W-11 -: 2];
  assign rec_err   = rec_head[CNT_W+SUM_W];
  assign rec_cnt   = rec_head[SUM_W +: CNT_W];
  assign rec_sum   = rec_head[SUM_W-1:0];
  assign ovf       = ovf_q;
  assign sw_err    = sw_err_q;

endmodule
`default_nettype wire

// File: tb/tb_obs_daq_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_obs_daq_acc
// Brief    : Scoreboard bench for obs_daq_acc; expected records are queued
//            by the stimulus and compared by an independent output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obs_daq_acc;

  typedef struct packed {
    logic [9:0]  rot;
    logic [1:0]  src;
    logic        err;
    logic [15:0] cnt;
    logic [31:0] sum;
  } rec_t;

  logic        clk50 = 1'b0;
  logic        sys_init_n = 1'b0;
  logic        wrk_stat = 1'b0;
  logic        adc_en = 1'b0;
  logic        adc_en4 = 1'b0;
  logic [3:0]  rf_sw = 4'b0001;
  logic [9:0]  rot_count = '0;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = '0;
  logic        rec_ready = 1'b0;
  logic        rec_ready4 = 1'b0;

  logic        rec_valid, rec_err, ovf, sw_err;
  logic [9:0]  rec_rot;
  logic [1:0]  rec_src;
  logic [15:0] rec_cnt;
  logic [31:0] rec_sum;

  logic        rec_valid4, rec_err4, ovf4, sw_err4;
  logic [9:0]  rec_rot4;
  logic [1:0]  rec_src4;
  logic [3:0]  rec_cnt4;
  logic [19:0] rec_sum4;

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];

  always #10 clk50 = ~clk50;

  obs_daq_acc #(.DATA_W(16), .CNT_W(16), .FIFO_DEPTH(4)) u_dut (
    .clk50(clk50), .sys_init_n(sys_init_n), .wrk_stat(wrk_stat),
    .adc_en(adc_en), .rf_sw(rf_sw), .rot_count(rot_count),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_rot(rec_rot), .rec_src(rec_src), .rec_err(rec_err),
    .rec_cnt(rec_cnt), .rec_sum(rec_sum), .ovf(ovf), .sw_err(sw_err)
  );

  obs_daq_acc #(.DATA_W(16), .CNT_W(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk50(clk50), .sys_init_n(sys_init_n), .wrk_stat(wrk_stat),
    .adc_en(adc_en4), .rf_sw(rf_sw), .rot_count(rot_count),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .rec_valid(rec_valid4), .rec_ready(rec_ready4),
    .rec_rot(rec_rot4), .rec_src(rec_src4), .rec_err(rec_err4),
    .rec_cnt(rec_cnt4), .rec_sum(rec_sum4), .ovf(ovf4), .sw_err(sw_err4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted record is popped from the scoreboard and compared
  always @(negedge clk50) begin
    if (rec_valid && rec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_record: got rot=%0d src=%0d err=%0d cnt=%0d sum=%0d, none expected",
                 rec_rot, rec_src, rec_err, rec_cnt, rec_sum);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if ({rec_rot, rec_src, rec_err, rec_cnt, rec_sum} !== e) begin
          failures++;
          $display("FAIL record: got rot=%0d src=%0d err=%0d cnt=%0d sum=%0d expected rot=%0d src=%0d err=%0d cnt=%0d sum=%0d",
                   rec_rot, rec_src, rec_err, rec_cnt, rec_sum, e.rot, e.src, e.err, e.cnt, e.sum);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk50);
      #2;
    end
  endtask

  // Opens a window on the selected DUT, streams n samples of v, and leaves
  // adc_en high; the caller closes the window.
  task automatic open_window(input logic [9:0] rot, input logic [3:0] sw,
                             input int n, input logic [15:0] v, input bit sel4);
    rot_count = rot;
    rf_sw     = sw;
    tick(3);
    if (sel4) adc_en4 = 1'b1; else adc_en = 1'b1;
    tick(4);
    adc_valid = 1'b1;
    adc_data  = v;
    tick(n);
    adc_valid = 1'b0;
    adc_data  = '0;
    tick(2);
  endtask

  task automatic push_exp(input logic [9:0] rot, input logic [1:0] src, input logic err,
                          input logic [15:0] cnt, input logic [31:0] sum);
    rec_t e;
    e.rot = rot; e.src = src; e.err = err; e.cnt = cnt; e.sum = sum;
    exp_q.push_back(e);
  endtask

  initial begin
    int lat;
    tick(3);
    chk("reset_rec_valid", 64'(rec_valid), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_sw_err", 64'(sw_err), 64'd0);
    chk("reset_rec_cnt", 64'(rec_cnt), 64'd0);
    chk("reset_rec_sum", 64'(rec_sum), 64'd0);
    sys_init_n = 1'b1;
    wrk_stat   = 1'b1;
    rec_ready  = 1'b1;
    tick(4);

    // 1: basic record and close-to-valid latency
    push_exp(10'd5, 2'd1, 1'b0, 16'd10, 32'd1000);
    open_window(10'd5, 4'b0010, 10, 16'd100, 1'b0);
    adc_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rec_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd5);
    tick(6);

    // 2: FIFO fill, overflow, in-order drain
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push_exp(10'(i), 2'd0, 1'b0, 16'd2, 32'(20 * (i + 1)));
      open_window(10'(i), 4'b0001, 2, 16'(10 * (i + 1)), 1'b0);
      adc_en = 1'b0;
      tick(10);
    end
    chk("ovf_after_fifo_full", 64'(ovf), 64'd1);
    chk("valid_while_held", 64'(rec_valid), 64'd1);
    rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_back_to_back", 64'(rec_valid), 64'd1);
    end
    tick();
    chk("drain_empty", 64'(rec_valid), 64'd0);
    tick(4);

    // 3: invalid rf_sw
    push_exp(10'd6, 2'd0, 1'b1, 16'd3, 32'd21);
    open_window(10'd6, 4'b0000, 3, 16'd7, 1'b0);
    adc_en = 1'b0;
    tick(10);
    chk("sw_err_sticky", 64'(sw_err), 64'd1);

    // 4: abort mid-window, then a normal window
    open_window(10'd3, 4'b0100, 3, 16'd5, 1'b0);
    wrk_stat = 1'b0;
    tick(4);
    adc_en = 1'b0;
    tick(10);
    chk("abort_no_record", 64'(rec_valid), 64'd0);
    wrk_stat = 1'b1;
    tick(4);
    push_exp(10'd4, 2'd3, 1'b0, 16'd4, 32'd36);
    open_window(10'd4, 4'b1000, 4, 16'd9, 1'b0);
    adc_en = 1'b0;
    tick(10);

    // 5: count saturation on the narrow-counter instance
    open_window(10'd7, 4'b0001, 20, 16'd2, 1'b1);
    adc_en4 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rec_valid4) begin
        lat = k;
        break;
      end
    end
    chk("sat_rec_valid_latency", 64'(lat), 64'd5);
    chk("sat_cnt", 64'(rec_cnt4), 64'd15);
    chk("sat_sum", 64'(rec_sum4), 64'd30);
    chk("sat_err", 64'(rec_err4), 64'd1);
    chk("sat_rot", 64'(rec_rot4), 64'd7);
    rec_ready4 = 1'b1;
    tick();
    rec_ready4 = 1'b0;
    chk("sat_popped", 64'(rec_valid4), 64'd0);
    tick(4);

    // 6: reset mid-window with two records queued
    rec_ready = 1'b0;
    push_exp(10'd8, 2'd1, 1'b0, 16'd1, 32'd3);
    open_window(10'd8, 4'b0010, 1, 16'd3, 1'b0);
    adc_en = 1'b0;
    tick(10);
    push_exp(10'd9, 2'd1, 1'b0, 16'd1, 32'd4);
    open_window(10'd9, 4'b0010, 1, 16'd4, 1'b0);
    adc_en = 1'b0;
    tick(10);
    chk("two_queued_valid", 64'(rec_valid), 64'd1);
    open_window(10'd10, 4'b0010, 2, 16'd6, 1'b0);
    sys_init_n = 1'b0;
    tick();
    sys_init_n = 1'b1;
    adc_en = 1'b0;
    exp_q.delete();
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_sw_err", 64'(sw_err), 64'd0);
    chk("rst_rec_rot", 64'(rec_rot), 64'd0);
    tick(10);
    chk("rst_no_record", 64'(rec_valid), 64'd0);
    rec_ready = 1'b1;
    tick(5);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
